uart_tx_frame: RTL and testbench

//  Parametrised UART transmitter: serialises DATA_BITS-wide words, LSB first, framed as

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_tick.sv | 47 ++++
 rtl/uart_tx_frame.sv | 204 ++++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared FSM encoding, parameter limits and helper functions for the UART transmitter.
// The optional parity stage of uart_tx_frame is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int MIN_CLKS_PER_BIT = 4;
  localparam int MIN_DATA_BITS    = 5;
  localparam int MAX_DATA_BITS    = 9;
  localparam int MIN_STOP_BITS    = 1;
  localparam int MAX_STOP_BITS    = 2;
  // Wide enough for the largest data-bit index (8).
  localparam int BIT_CNT_W        = 4;

  function automatic int baud_cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1, restartable, flags the last and
// second-to-last cycle of each bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic bit_end_o,
  output logic pre_end_o
);
  import uart_pkg::*;

  localparam int               CNT_W    = baud_cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart wins, otherwise wrap at the bit boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = (cnt_q == CNT_LAST);
  assign pre_end_o = (cnt_q == CNT_PRE);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_BITS data bits LSB first, optional parity, STOP_BITS stops.
// Define UART_TX_PARITY_EN to insert the parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] d_tx,
  input  logic                 vld_tx,
  output logic                 rdy_tx,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);
  import uart_pkg::*;

  localparam logic [BIT_CNT_W-1:0] BIT_ZERO  = {BIT_CNT_W{1'b0}};
  localparam logic [BIT_CNT_W-1:0] BIT_ONE   = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);

  tx_state_e            state_q;
  tx_state_e            state_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [BIT_CNT_W-1:0] bit_cnt_d;
  logic                 txd_q;
  logic                 txd_d;
  logic                 busy_q;
  logic                 busy_d;
  logic                 done_q;
  logic                 done_d;
  logic                 bit_end_s;
  logic                 pre_end_s;
  logic                 accept_s;
  logic                 last_stop_s;
  logic                 restart_s;

  // The counter idles at zero so every frame starts on a fresh bit time.
  assign restart_s = (state_q == ST_IDLE) || accept_s;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i    (clk),
    .rst_i    (rst),
    .restart_i(restart_s),
    .bit_end_o(bit_end_s),
    .pre_end_o(pre_end_s)
  );

  assign last_stop_s = (state_q == ST_STOP) && bit_end_s && (bit_cnt_q == STOP_LAST);
  assign rdy_tx      = !rst && ((state_q == ST_IDLE) || last_stop_s);
  assign accept_s    = rdy_tx && vld_tx;

`ifdef UART_TX_PARITY_EN
  logic par_q;
  logic par_d;

  // Parity is captured at acceptance because the shift register is consumed as bits go out.
  always_comb begin
    if (accept_s) begin
      par_d = parity_bit(MAX_DATA_BITS'(d_tx), (PARITY_ODD != 0));
    end else begin
      par_d = par_q;
    end
  end

  // Parity register.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s && (bit_cnt_q == DATA_LAST)) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        // A word accepted in the final stop cycle chains straight into its start bit.
        if (last_stop_s) begin
          state_d = accept_s ? ST_START : ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift register and per-state bit counter.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (accept_s) begin
      shift_d   = d_tx;
      bit_cnt_d = BIT_ZERO;
    end else if (bit_end_s) begin
      if (state_q == ST_DATA) begin
        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
      end else begin
        shift_d = shift_q;
      end
      if (state_d != state_q) begin
        bit_cnt_d = BIT_ZERO;
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_ONE;
      end
    end else begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Output decode from the upcoming state so txd, busy and tx_done come straight from flops.
  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_STOP) && (bit_cnt_q == STOP_LAST) && pre_end_s;
    case (state_d)
      ST_IDLE:   txd_d = 1'b1;
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = par_q;
`endif
      ST_STOP:   txd_d = 1'b1;
      default:   txd_d = 1'b1;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= {DATA_BITS{1'b0}};
      bit_cnt_q <= BIT_ZERO;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign txd     = txd_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: three configurations checked every cycle against
// a frame-level model, plus hand-computed frame patterns. Honours UART_TX_PARITY_EN.
module tb_uart_tx_frame;

  localparam int NI  = 3;
  localparam int CPB = 16;
  localparam int DB_T [NI] = '{8, 8, 5};
  localparam int SB_T [NI] = '{1, 2, 1};
  localparam int PO_T [NI] = '{0, 0, 1};

`ifdef UART_TX_PARITY_EN
  localparam bit          PAR_EN   = 1'b1;
  localparam logic [15:0] EXP_A5   = 16'hFD4A;
  localparam int          N_8B1S   = 11;
  localparam int          N_8B2S   = 12;
  localparam logic [15:0] EXP_07_5 = 16'hFF8E;
  localparam logic [15:0] EXP_13_5 = 16'hFFA6;
  localparam int          N_5B1S   = 8;
`else
  localparam bit          PAR_EN   = 1'b0;
  localparam logic [15:0] EXP_A5   = 16'hFF4A;
  localparam int          N_8B1S   = 10;
  localparam int          N_8B2S   = 11;
  localparam logic [15:0] EXP_07_5 = 16'hFFCE;
  localparam logic [15:0] EXP_13_5 = 16'hFFE6;
  localparam int          N_5B1S   = 7;
`endif
  // 8-bit 0x07 has the same frame pattern with or without (even) parity.
  localparam logic [15:0] EXP_07_8 = 16'hFE0E;

  logic          clk;
  logic [NI-1:0] rst_s;
  logic [NI-1:0] vld_s;
  logic [8:0]    d_s [NI];
  logic [NI-1:0] rdy_w;
  logic [NI-1:0] txd_w;
  logic [NI-1:0] busy_w;
  logic [NI-1:0] done_w;

  int checks;
  int errors;

  // Frame-level model state per instance.
  bit          m_armed  [NI];
  bit          m_active [NI];
  int          m_pos    [NI];
  int          m_nbits  [NI];
  logic [15:0] m_frame  [NI];
  int          m_acc    [NI];
  int          done_cnt [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_frame #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB_T[g]),
      .STOP_BITS   (SB_T[g]),
      .PARITY_ODD  (PO_T[g])
    ) u_dut (
      .clk    (clk),
      .rst    (rst_s[g]),
      .d_tx   (d_s[g][DB_T[g]-1:0]),
      .vld_tx (vld_s[g]),
      .rdy_tx (rdy_w[g]),
      .txd    (txd_w[g]),
      .busy   (busy_w[g]),
      .tx_done(done_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole frame as a bit list: start 0, data LSB first, optional parity, stop ones.
  function automatic logic [15:0] mk_frame(input int g, input logic [8:0] d, output int n);
    logic [15:0] f;
    logic        p;
    f    = 16'hFFFF;
    f[0] = 1'b0;
    p    = (PO_T[g] != 0);
    for (int i = 0; i < DB_T[g]; i++) begin
      f[1+i] = d[i];
      p      = p ^ d[i];
    end
    n = 1 + DB_T[g] + SB_T[g];
    if (PAR_EN) begin
      f[1+DB_T[g]] = p;
      n++;
    end
    return f;
  endfunction

  // Compare every instance against the model, then advance the model one clock.
  always @(negedge clk) begin
    int   last;
    logic e_rdy;
    int   n;
    for (int g = 0; g < NI; g++) begin
      last  = m_nbits[g] * CPB - 1;
      e_rdy = !rst_s[g] && (!m_active[g] || (m_pos[g] == last));
      if (m_armed[g]) begin
        chk($sformatf("txd%0d", g), 32'(txd_w[g]),
            32'(m_active[g] ? m_frame[g][m_pos[g] / CPB] : 1'b1));
        chk($sformatf("busy%0d", g), 32'(busy_w[g]), 32'(m_active[g]));
        chk($sformatf("done%0d", g), 32'(done_w[g]), 32'(m_active[g] && (m_pos[g] == last)));
        chk($sformatf("rdy%0d", g), 32'(rdy_w[g]), 32'(e_rdy));
        if (done_w[g] === 1'b1) done_cnt[g]++;
      end
      if (rst_s[g]) begin
        m_active[g] = 1'b0;
        m_armed[g]  = 1'b1;
      end else if (e_rdy && vld_s[g]) begin
        m_frame[g]  = mk_frame(g, d_s[g], n);
        m_nbits[g]  = n;
        m_active[g] = 1'b1;
        m_pos[g]    = 0;
        m_acc[g]++;
      end else if (m_active[g]) begin
        if (m_pos[g] == last) m_active[g] = 1'b0;
        else m_pos[g]++;
      end
    end
  end

  // Present a word and wait (bounded) for the posedge that accepts it; vld stays high.
  task automatic send(input int g, input logic [8:0] d, output int cyc);
    int c0;
    c0       = m_acc[g];
    d_s[g]   = d;
    vld_s[g] = 1'b1;
    cyc      = 0;
    while ((m_acc[g] == c0) && (cyc < 2000)) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk($sformatf("accept%0d", g), 32'(m_acc[g] != c0), 32'd1);
  endtask

  task automatic send_one(input int g, input logic [8:0] d);
    int cyc;
    send(g, d, cyc);
    vld_s[g] = 1'b0;
  endtask

  // Check a frame against a hand-computed bit pattern, starting in its first cycle.
  task automatic watch_frame(input int g, input logic [15:0] exp, input int n, input string tag);
    int done_at;
    int rdy_hi;
    done_at = 0;
    rdy_hi  = 0;
    for (int c = 1; c <= n * CPB; c++) begin
      @(negedge clk);
      if ((c % CPB) == 8) chk($sformatf("%s_bit%0d", tag, (c - 1) / CPB),
                              32'(txd_w[g]), 32'(exp[(c - 1) / CPB]));
      if (done_w[g] === 1'b1) done_at = c;
      if (rdy_w[g] === 1'b1) rdy_hi++;
    end
    chk($sformatf("%s_done_cycle", tag), 32'(done_at), 32'(n * CPB));
    chk($sformatf("%s_rdy_cycles", tag), 32'(rdy_hi), 32'd1);
  endtask

  initial begin
    int cyc;
    checks = 0;
    errors = 0;
    rst_s  = {NI{1'b1}};
    vld_s  = {NI{1'b0}};
    for (int i = 0; i < NI; i++) d_s[i] = 9'h000;

    // Reset state and rdy release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 32'(rdy_w), 32'h0);
    chk("rst_txd", 32'(txd_w), 32'h7);
    chk("rst_busy", 32'(busy_w), 32'h0);
    @(posedge clk);
    #1;
    rst_s = {NI{1'b0}};
    @(negedge clk);
    chk("rel_rdy", 32'(rdy_w), 32'h7);

    // 0xA5 on the 8-bit, 1-stop instance.
    @(posedge clk);
    #1;
    send_one(0, 9'h0A5);
    watch_frame(0, EXP_A5, N_8B1S, "a5");

    // Parity pattern checks: even on 0x07 (8 bits), odd on 0x07 (5 bits).
    repeat (3) @(posedge clk);
    #1;
    send_one(0, 9'h007);
    watch_frame(0, EXP_07_8, N_8B1S, "p07even");
    send_one(2, 9'h007);
    watch_frame(2, EXP_07_5, N_5B1S, "p07odd");

    // Back-to-back on the 2-stop instance with vld held high.
    @(posedge clk);
    #1;
    send(1, 9'h055, cyc);
    send(1, 9'h0AA, cyc);
    vld_s[1] = 1'b0;
    chk("b2b_gap", 32'(cyc), 32'(N_8B2S * CPB));
    repeat (N_8B2S * CPB + 4) @(posedge clk);
    #1;
    chk("b2b_done_count", 32'(done_cnt[1]), 32'd2);

    // Reset during data bit 3, then a clean frame.
    send_one(0, 9'h0C3);
    repeat (68) @(posedge clk);
    #1;
    rst_s[0] = 1'b1;
    @(posedge clk);
    #1;
    rst_s[0] = 1'b0;
    @(negedge clk);
    chk("abort_txd", 32'(txd_w[0]), 32'd1);
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    @(posedge clk);
    #1;
    send_one(0, 9'h0A5);
    watch_frame(0, EXP_A5, N_8B1S, "a5_after_rst");

    // 5-bit word 0x13.
    send_one(2, 9'h013);
    watch_frame(2, EXP_13_5, N_5B1S, "d13");

    repeat (20) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
